// File: rtl/digit_pkg.sv
// Shared widths, state encoding and seven-segment table for the digit stabilizer.
package digit_pkg;

    localparam int DIGIT_W     = 4;
    localparam int NUM_CLASSES = 10;
    localparam int SEG_W       = 7;

    // gfedcba, active-high
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [SEG_W-1:0] seg7_lookup(input logic [DIGIT_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/digit_stabilizer_if.sv
// Sample/control inputs and committed-digit outputs of the digit stabilizer.
interface digit_stabilizer_if;
    import digit_pkg::*;

    logic                en;
    logic                clr;
    logic [DIGIT_W-1:0]  pred_in;
    logic [DIGIT_W-1:0]  digit_out;
    logic                digit_valid;
    logic [SEG_W-1:0]    seg_out;
    logic                commit_pulse;
    logic                err_pulse;
    logic [7:0]          commit_count;

    modport master (
        output en, clr, pred_in,
        input  digit_out, digit_valid, seg_out, commit_pulse, err_pulse, commit_count
    );

    modport slave (
        input  en, clr, pred_in,
        output digit_out, digit_valid, seg_out, commit_pulse, err_pulse, commit_count
    );

endinterface

// File: rtl/seg7_encoder.sv
// Combinational digit to gfedcba lookup; blanks for invalid digits or blank=1.
module seg7_encoder
    import digit_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               blank,
    output logic [SEG_W-1:0]   seg
);

    always_comb begin
        seg = '0;
        if (!blank) begin
            seg = seg7_lookup(digit);
        end
    end

endmodule

// File: rtl/digit_stabilizer.sv
// Commits a classifier prediction once it has been seen on STABLE_CYCLES
// consecutive enabled samples; drives digit, segments, pulses and a commit count.
//
// state   | meaning
// --------+-------------------------------------------------------
// EMPTY   | nothing committed since reset/clr, digit_valid=0
// PENDING | digit committed, a run toward a different digit active
// LOCKED  | digit committed, candidate equals the committed digit
module digit_stabilizer
    import digit_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int RUN_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    digit_stabilizer_if.slave bus
);

    localparam logic [RUN_W-1:0] STABLE_R = RUN_W'(STABLE_CYCLES);

    state_t             state, state_nxt;
    logic [DIGIT_W-1:0] cand, cand_nxt;
    logic [RUN_W-1:0]   run, run_nxt;
    logic [DIGIT_W-1:0] digit, digit_nxt;
    logic               valid, valid_nxt;
    logic [SEG_W-1:0]   seg, seg_nxt;
    logic               commit_pulse_q, err_pulse_q;
    logic [7:0]         count, count_nxt;
    logic               commit, sample_err;
    logic               pred_invalid;

    assign pred_invalid = (bus.pred_in >= DIGIT_W'(NUM_CLASSES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority: clr, then en=0 (hold), then the sample itself.
    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        run_nxt    = run;
        commit     = 1'b0;
        sample_err = 1'b0;
        if (bus.clr) begin
            state_nxt = EMPTY;
            cand_nxt  = '0;
            run_nxt   = '0;
        end else if (bus.en) begin
            if (pred_invalid) begin
                run_nxt    = '0;
                sample_err = 1'b1;
            end else begin
                if (bus.pred_in == cand && run != '0) begin
                    run_nxt = (run == STABLE_R) ? STABLE_R : run + RUN_W'(1);
                end else begin
                    cand_nxt = bus.pred_in;
                    run_nxt  = RUN_W'(1);
                end
                if (run_nxt == STABLE_R && (state == EMPTY || cand_nxt != digit)) begin
                    commit    = 1'b1;
                    state_nxt = LOCKED;
                end else if (state != EMPTY) begin
                    // a run that falls back onto the committed digit relocks silently
                    state_nxt = (cand_nxt == digit) ? LOCKED : PENDING;
                end
            end
        end
    end

    always_comb begin
        digit_nxt = digit;
        valid_nxt = valid;
        count_nxt = count;
        if (bus.clr) begin
            digit_nxt = '0;
            valid_nxt = 1'b0;
        end else if (commit) begin
            digit_nxt = cand_nxt;
            valid_nxt = 1'b1;
            count_nxt = count + 8'd1;
        end
    end

    // Encoding the next digit keeps seg_out aligned with digit_out.
    seg7_encoder u_seg (
        .digit (digit_nxt),
        .blank (!valid_nxt),
        .seg   (seg_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand           <= '0;
            run            <= '0;
            digit          <= '0;
            valid          <= 1'b0;
            seg            <= '0;
            commit_pulse_q <= 1'b0;
            err_pulse_q    <= 1'b0;
            count          <= '0;
        end else begin
            cand           <= cand_nxt;
            run            <= run_nxt;
            digit          <= digit_nxt;
            valid          <= valid_nxt;
            seg            <= seg_nxt;
            commit_pulse_q <= commit;
            err_pulse_q    <= sample_err;
            count          <= count_nxt;
        end
    end

    assign bus.digit_out    = digit;
    assign bus.digit_valid  = valid;
    assign bus.seg_out      = seg;
    assign bus.commit_pulse = commit_pulse_q;
    assign bus.err_pulse    = err_pulse_q;
    assign bus.commit_count = count;

endmodule

// File: tb/tb_digit_stabilizer.sv
// Directed bench for digit_stabilizer with STABLE_CYCLES=4.
module tb_digit_stabilizer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   pulses;
    int   errs;

    digit_stabilizer_if bus ();

    digit_stabilizer #(.STABLE_CYCLES(4), .RUN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic [3:0] p);
        bus.en      = e;
        bus.clr     = c;
        bus.pred_in = p;
        @(posedge clk);
        #1;
        pulses += int'(bus.commit_pulse);
        errs   += int'(bus.err_pulse);
    endtask

    initial begin
        checks = 0; failures = 0; pulses = 0; errs = 0;
        bus.en = 1'b0; bus.clr = 1'b0; bus.pred_in = 4'd0;
        rst_n = 1'b0;
        #12;
        check("rst_digit",  32'(bus.digit_out), 32'd0);
        check("rst_valid",  32'(bus.digit_valid), 32'd0);
        check("rst_seg",    32'(bus.seg_out), 32'h00);
        check("rst_pulses", {30'd0, bus.commit_pulse, bus.err_pulse}, 32'd0);
        check("rst_count",  32'(bus.commit_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // first commit: 5 x4
        step(1, 0, 5); step(1, 0, 5); step(1, 0, 5);
        check("pre5_valid", 32'(bus.digit_valid), 32'd0);
        check("pre5_seg",   32'(bus.seg_out), 32'h00);
        step(1, 0, 5);
        check("c5_digit", 32'(bus.digit_out), 32'd5);
        check("c5_seg",   32'(bus.seg_out), 32'h6D);
        check("c5_pulse", 32'(bus.commit_pulse), 32'd1);
        check("c5_count", 32'(bus.commit_count), 32'd1);
        step(0, 0, 5);
        check("c5_pulse_once", 32'(bus.commit_pulse), 32'd0);

        // 7,7,3,7,7,7,7 -> one commit at the end
        pulses = 0;
        step(1, 0, 7); step(1, 0, 7); step(1, 0, 3);
        step(1, 0, 7); step(1, 0, 7); step(1, 0, 7);
        check("p7_no_early", pulses, 0);
        check("p7_still5",   32'(bus.digit_out), 32'd5);
        step(1, 0, 7);
        check("c7_digit",  32'(bus.digit_out), 32'd7);
        check("c7_seg",    32'(bus.seg_out), 32'h07);
        check("c7_count",  32'(bus.commit_count), 32'd2);
        check("c7_pulses", pulses, 1);

        // hold 7 for 20 samples
        pulses = 0;
        for (int i = 0; i < 20; i++) step(1, 0, 7);
        check("hold7_pulses", pulses, 0);
        check("hold7_count",  32'(bus.commit_count), 32'd2);
        check("hold7_run",    32'(dut.run), 32'd4);

        // 2,2,12,2,2,2,2 -> error breaks the run
        pulses = 0; errs = 0;
        step(1, 0, 2); step(1, 0, 2); step(1, 0, 12);
        check("e12_err",  32'(bus.err_pulse), 32'd1);
        check("e12_run",  32'(dut.run), 32'd0);
        step(1, 0, 2);
        check("e12_err_once", 32'(bus.err_pulse), 32'd0);
        step(1, 0, 2); step(1, 0, 2);
        check("p2_no_early", pulses, 0);
        check("p2_still7",   32'(bus.digit_out), 32'd7);
        step(1, 0, 2);
        check("c2_digit",  32'(bus.digit_out), 32'd2);
        check("c2_seg",    32'(bus.seg_out), 32'h5B);
        check("c2_count",  32'(bus.commit_count), 32'd3);
        check("c2_pulses", pulses, 1);
        check("c2_errs",   errs, 1);

        // 9,9, en=0 gap, 9,9
        pulses = 0;
        step(1, 0, 9); step(1, 0, 9);
        for (int i = 0; i < 5; i++) step(0, 0, 4);
        step(1, 0, 9);
        check("p9_no_early", pulses, 0);
        step(1, 0, 9);
        check("c9_digit", 32'(bus.digit_out), 32'd9);
        check("c9_seg",   32'(bus.seg_out), 32'h6F);
        check("c9_count", 32'(bus.commit_count), 32'd4);

        // clr wins over a valid sample
        step(1, 1, 9);
        check("clr_valid", 32'(bus.digit_valid), 32'd0);
        check("clr_digit", 32'(bus.digit_out), 32'd0);
        check("clr_seg",   32'(bus.seg_out), 32'h00);
        check("clr_pulse", 32'(bus.commit_pulse), 32'd0);
        check("clr_count", 32'(bus.commit_count), 32'd4);

        // async reset mid-run
        step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        check("mid_run3", 32'(dut.run), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(bus.commit_count), 32'd0);
        check("arst_run",   32'(dut.run), 32'd0);
        check("arst_valid", 32'(bus.digit_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        check("post_rst_no_commit", pulses, 0);
        step(1, 0, 1);
        check("post_rst_digit", 32'(bus.digit_out), 32'd1);
        check("post_rst_count", 32'(bus.commit_count), 32'd1);

        // 256 commits wrap the counter
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++) step(1, 0, (i % 2 == 0) ? 4'd3 : 4'd4);
            if (i == 254) check("wrap_255", 32'(bus.commit_count), 32'd255);
        end
        check("wrap_0",      32'(bus.commit_count), 32'd0);
        check("wrap_pulses", pulses, 256);
        check("wrap_digit",  32'(bus.digit_out), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
